// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, imem request/grant/response, registered prefetch FIFO.
// Optional IFETCH_MISALIGN_CHECK_EN: halt on misaligned redirect and raise fetch_misaligned.
module ifetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk1,
   input  logic                  reset1,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
`ifdef IFETCH_MISALIGN_CHECK_EN
   output logic                  fetch_misaligned,
`endif
   input  logic                  instr_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   // Extra headroom: back-to-back redirects can stack discards beyond FIFO_DEPTH.
   localparam int CNT_W = OCC_W + 4;
   localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(4);

   typedef enum logic {RUN, HALT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
   logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] tag_q  [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [CNT_W-1:0]      pend_q, pend_d;
   logic [CNT_W-1:0]      drop_q, drop_d;

   logic [ADDR_WIDTH-1:0] redir_pc;
   logic                  misalign;
   logic                  req_int;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [CNT_W-1:0]      fill;

`ifdef IFETCH_MISALIGN_CHECK_EN
   assign redir_pc         = redirect_pc;
   assign misalign         = |redirect_pc[1:0];
   assign fetch_misaligned = (state_q == HALT);
`else
   assign redir_pc = redirect_pc & ~ADDR_WIDTH'(3);
   assign misalign = 1'b0;
`endif

   assign instr_valid = (occ_q != '0) && !redirect;
   assign instr       = data_q[rd_ptr_q];
   assign instr_pc    = tag_q[rd_ptr_q];
   assign pop         = instr_valid && instr_ready;

   // Crediting this cycle's pop keeps one instruction per cycle with a 2-entry FIFO.
   assign fill     = CNT_W'(occ_q) - CNT_W'(pop) + (pend_q - drop_q);
   assign req_int  = (state_q == RUN) && !redirect && (fill < DEPTH_C) && (pend_q != '1);
   assign imem_req = req_int && reset1;
   assign imem_addr = pc_q;
   assign accept   = req_int && imem_gnt;
   assign push     = imem_rvalid && (drop_q == '0) && !redirect;

   // Live responses follow consecutive addresses from the last redirect, so one
   // running PC register tags them in order instead of a per-request tag queue.
   always_comb begin
      pend_d   = pend_q + CNT_W'(accept) - CNT_W'(imem_rvalid);
      drop_d   = drop_q;
      occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
      pc_d     = accept ? pc_q + STEP_C : pc_q;
      rsp_pc_d = push ? rsp_pc_q + STEP_C : rsp_pc_q;
      state_d  = state_q;
      if (imem_rvalid && (drop_q != '0)) begin
         drop_d = drop_q - CNT_W'(1);
      end
      if (redirect) begin
         occ_d    = '0;
         pc_d     = redir_pc;
         rsp_pc_d = redir_pc;
         drop_d   = pend_d;
         state_d  = misalign ? HALT : RUN;
      end
   end

   always_ff @(posedge clk1 or negedge reset1) begin
      if (!reset1) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         occ_q    <= '0;
         pend_q   <= '0;
         drop_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         occ_q    <= occ_d;
         pend_q   <= pend_d;
         drop_q   <= drop_d;
         if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               data_q[wr_ptr_q] <= imem_rdata;
               tag_q[wr_ptr_q]  <= rsp_pc_q;
               wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory model with variable latency, in-order scoreboard,
// table of redirect/stall phases and hand sequences for latency, misalign and reset.
module tb_ifetch_unit;

   logic        clk1 = 1'b0;
   logic        reset1 = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   ifetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk1        (clk1),
      .reset1      (reset1),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
`ifdef IFETCH_MISALIGN_CHECK_EN
      .fetch_misaligned (fetch_misaligned),
`endif
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk1 = ~clk1;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
   endtask

   // Memory: accepts sampled mid-cycle, answered in order after lat cycles.
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int    lat = 1;
   int    cyc = 0;

   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk1);
         if (reset1 && imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
         @(posedge clk1);
         #1;
         cyc++;
         if (!reset1) begin
            mq.delete();
            imem_rvalid = 1'b0;
         end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mdata(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            imem_rvalid = 1'b0;
         end
      end
   end

   // Scoreboard: expectation pushed on accept from the bench's own PC model.
   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] model_pc = 32'h0;
   int          n_pop = 0;
   int          n_acc = 0;

   always @(negedge clk1) begin
      exp_t e;
      if (!reset1) begin
         exp_q.delete();
         model_pc = 32'h0;
      end else if (redirect) begin
         chk("req_in_redirect", {31'b0, imem_req}, 32'h0);
         chk("valid_in_redirect", {31'b0, instr_valid}, 32'h0);
         exp_q.delete();
         model_pc = redirect_pc & ~32'h3;
      end else begin
         if (instr_valid && instr_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_unexpected: got instr_pc 0x%08h expected no instruction", instr_pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", instr_pc, e.pc);
               chk("sb_data", instr, e.data);
            end
         end
         if (imem_req && imem_gnt) begin
            chk("req_addr", imem_addr, model_pc);
            exp_q.push_back('{model_pc, mdata(model_pc)});
            model_pc += 32'h4;
            n_acc++;
         end
      end
   end

   typedef struct {
      logic        do_redir;
      logic [31:0] pc;
      logic        gnt;
      logic        ready;
      int          cycles;
      int          exp_acc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_ipc;
   } vec_t;
   vec_t vecs[$];

   initial begin
      int a0;
      int p0;
      int first;
      vec_t v;

      imem_gnt    = 1'b1;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;

      vecs.push_back('{1'b1, 32'h0000_0040, 1'b1, 1'b0, 10, 2, 1'b0, 32'h0000_0048, 1'b1, 32'h0000_0040});
      vecs.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b1,  3, 4, 1'b1, 32'h0000_0054, 1'b1, 32'h0000_004C});
      vecs.push_back('{1'b1, 32'h0000_0008, 1'b0, 1'b1,  5, 0, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0000});
      vecs.push_back('{1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1,  6, 6, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004});
      vecs.push_back('{1'b1, 32'h0000_0200, 1'b1, 1'b1,  4, 4, 1'b1, 32'h0000_020C, 1'b1, 32'h0000_0204});
`ifndef IFETCH_MISALIGN_CHECK_EN
      vecs.push_back('{1'b1, 32'h0000_0102, 1'b1, 1'b1,  4, 4, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104});
`endif

      repeat (2) @(posedge clk1);
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_ipc", instr_pc, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
      chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);
`endif
      reset1 = 1'b1;

      @(negedge clk1); #1;
      chk("first_req", {31'b0, imem_req}, 32'h1);
      chk("valid_c0", {31'b0, instr_valid}, 32'h0);
      @(negedge clk1); #1;
      chk("valid_c1", {31'b0, instr_valid}, 32'h0);
      @(negedge clk1); #1;
      chk("valid_c2", {31'b0, instr_valid}, 32'h1);
      chk("ipc_c2", instr_pc, 32'h0);
      chk("instr_c2", instr, mdata(32'h0));
      p0 = n_pop;
      repeat (10) begin
         @(negedge clk1); #1;
      end
      chk("throughput", 32'(n_pop - p0), 32'd10);
      chk("ipc_c12", instr_pc, 32'h28);

      for (int r = 0; r < vecs.size(); r++) begin
         v = vecs[r];
         @(posedge clk1); #1;
         imem_gnt    = v.gnt;
         instr_ready = v.ready;
         if (v.do_redir) begin
            redirect    = 1'b1;
            redirect_pc = v.pc;
         end
         a0 = n_acc;
         @(posedge clk1); #1;
         redirect = 1'b0;
         for (int c = 0; c < v.cycles; c++) begin
            @(negedge clk1); #1;
            if (!v.gnt) chk($sformatf("addr_hold_r%0d", r), imem_addr, v.pc);
         end
         chk($sformatf("acc_r%0d", r), 32'(n_acc - a0), 32'(v.exp_acc));
         chk($sformatf("req_r%0d", r), {31'b0, imem_req}, {31'b0, v.exp_req});
         chk($sformatf("addr_r%0d", r), imem_addr, v.exp_addr);
         chk($sformatf("valid_r%0d", r), {31'b0, instr_valid}, {31'b0, v.exp_valid});
         if (v.exp_valid) chk($sformatf("ipc_r%0d", r), instr_pc, v.exp_ipc);
      end

      // Two requests outstanding on a slow memory when the redirect lands.
      @(posedge clk1); #1;
      lat         = 3;
      imem_gnt    = 1'b1;
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      @(posedge clk1); #1;
      redirect = 1'b0;
      a0 = n_acc;
      @(posedge clk1); #1;
      @(posedge clk1); #1;
      chk("lat3_outstanding", 32'(n_acc - a0), 32'd2);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      @(posedge clk1); #1;
      redirect = 1'b0;
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk1); #1;
         if (instr_valid) begin
            first = i;
            break;
         end
      end
      chk("lat3_first_valid", 32'(first), 32'd5);
      chk("lat3_ipc", instr_pc, 32'h100);
      chk("lat3_instr", instr, mdata(32'h100));
      lat = 1;

`ifdef IFETCH_MISALIGN_CHECK_EN
      @(posedge clk1); #1;
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      @(posedge clk1); #1;
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk1); #1;
         chk("halt_flag", {31'b0, fetch_misaligned}, 32'h1);
         chk("halt_no_req", {31'b0, imem_req}, 32'h0);
      end
      @(posedge clk1); #1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      chk("flag_in_redirect", {31'b0, fetch_misaligned}, 32'h1);
      @(posedge clk1); #1;
      redirect = 1'b0;
      @(negedge clk1); #1;
      chk("unhalt_flag", {31'b0, fetch_misaligned}, 32'h0);
      chk("unhalt_req", {31'b0, imem_req}, 32'h1);
      chk("unhalt_addr", imem_addr, 32'h200);
      first = 0;
      for (int i = 2; i <= 10; i++) begin
         @(negedge clk1); #1;
         if (instr_valid) begin
            first = i;
            break;
         end
      end
      chk("unhalt_first_valid", 32'(first), 32'd3);
      chk("unhalt_ipc", instr_pc, 32'h200);
`endif

      // Reset in the middle of streaming.
      repeat (3) @(posedge clk1);
      #1;
      reset1 = 1'b0;
      #1;
      chk("mrst_req", {31'b0, imem_req}, 32'h0);
      chk("mrst_valid", {31'b0, instr_valid}, 32'h0);
      chk("mrst_addr", imem_addr, 32'h0);
      chk("mrst_ipc", instr_pc, 32'h0);
      chk("mrst_instr", instr, 32'h0);
      repeat (2) @(posedge clk1);
      #1;
      reset1 = 1'b1;
      first = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1); #1;
         if (instr_valid) begin
            first = i;
            break;
         end
      end
      chk("mrst_first_valid", 32'(first), 32'd2);
      chk("mrst_ipc", instr_pc, 32'h0);
      repeat (4) @(posedge clk1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
